// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
//   Handshake and data bundle for the pipelined carry-lookahead adder.
//   master : the side that supplies operands and consumes results.
//   slave  : the adder itself.
//
//   Input side  : in_valid, in_ready, in_a, in_b, in_cin, in_sub
//   Output side : out_valid, out_ready, out_sum, out_cout, out_ovf
//   Optional    : out_zero, out_neg (present only when CLA_PIPE_FLAGS_EN is defined)
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
`ifdef CLA_PIPE_FLAGS_EN
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
`endif

endinterface : cla_pipe_adder_if

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Two-stage pipelined carry-lookahead adder/subtractor.
//   Stage 1 registers per-bit propagate/generate and per-group PG/GG terms.
//   Stage 2 resolves group carries through a fully expanded lookahead, ripples
//   the carries inside each group from the registered p/g, and registers sum,
//   carry-out and signed overflow. Valid/ready on both sides, 1 item/cycle.
//
// Parameters
//   WIDTH  operand width (multiple of GROUP)
//   GROUP  bits per lookahead group
//
// Ports
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      cla_pipe_adder_if.slave:
//              in_valid/in_ready/in_a/in_b/in_cin/in_sub   operand side
//              out_valid/out_ready/out_sum/out_cout/out_ovf result side
//
// Configuration
//   CLA_PIPE_FLAGS_EN  adds registered out_zero (sum==0) and out_neg (sum MSB).
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    cla_pipe_adder_if.slave  bus
);

    localparam int NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
    end

    // -------------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or is being drained.
    // in_ready is built only from pipeline state, never from in_valid.
    // -------------------------------------------------------------------------
    logic w_adv1;
    logic w_adv2;

    logic r_s1_valid;
    logic r_s2_valid;

    assign w_adv2      = !r_s2_valid || bus.out_ready;
    assign w_adv1      = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1;

    // -------------------------------------------------------------------------
    // Stage 1 combinational: operand conditioning and group P/G
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_bb;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic             w_c0;
    logic [NG-1:0]    w_pg;
    logic [NG-1:0]    w_gg;

    always_comb begin
        logic v_acc;
        // NOTE: every variable written here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        w_pg  = '0;
        w_gg  = '0;
        v_acc = 1'b0;

        // Subtraction is A + ~B + 1; the forced carry-in overrides in_cin.
        w_bb = bus.in_sub ? ~bus.in_b : bus.in_b;
        w_c0 = bus.in_sub | bus.in_cin;
        w_p  = bus.in_a ^ w_bb;
        w_g  = bus.in_a & w_bb;

        for (int k = 0; k < NG; k++) begin
            w_pg[k] = &w_p[k*GROUP +: GROUP];
            // Folding from the LSB upward yields g[top] | p[top]&g[top-1] | ...
            v_acc = 1'b0;
            for (int i = 0; i < GROUP; i++) begin
                v_acc = w_g[k*GROUP+i] | (w_p[k*GROUP+i] & v_acc);
            end
            w_gg[k] = v_acc;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic [NG-1:0]    r_s1_pg;
    logic [NG-1:0]    r_s1_gg;
    logic             r_s1_c0;
    logic             r_s1_a_msb;
    logic             r_s1_bb_msb;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: datapath registers are reset along with the valid bits; they
        // are few, and it keeps the outputs at a defined zero out of reset.
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_p      <= '0;
            r_s1_g      <= '0;
            r_s1_pg     <= '0;
            r_s1_gg     <= '0;
            r_s1_c0     <= 1'b0;
            r_s1_a_msb  <= 1'b0;
            r_s1_bb_msb <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_p      <= w_p;
                r_s1_g      <= w_g;
                r_s1_pg     <= w_pg;
                r_s1_gg     <= w_gg;
                r_s1_c0     <= w_c0;
                r_s1_a_msb  <= bus.in_a[WIDTH-1];
                r_s1_bb_msb <= w_bb[WIDTH-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 combinational: lookahead across groups, ripple within a group
    // -------------------------------------------------------------------------
    logic [NG:0]      w_gc;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    always_comb begin
        logic v_term;
        logic v_c;
        w_gc    = '0;
        w_carry = '0;
        v_term  = 1'b0;
        v_c     = 1'b0;

        w_gc[0] = r_s1_c0;
        // Each group carry is a flat sum of products over all lower groups,
        // so no group carry waits on another group carry.
        for (int k = 0; k < NG; k++) begin
            v_term = r_s1_c0;
            for (int j = 0; j <= k; j++) begin
                v_term = v_term & r_s1_pg[j];
            end
            w_gc[k+1] = v_term;
            for (int j = 0; j <= k; j++) begin
                v_term = r_s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    v_term = v_term & r_s1_pg[m];
                end
                w_gc[k+1] = w_gc[k+1] | v_term;
            end
        end

        for (int k = 0; k < NG; k++) begin
            v_c = w_gc[k];
            for (int i = 0; i < GROUP; i++) begin
                w_carry[k*GROUP+i] = v_c;
                v_c = r_s1_g[k*GROUP+i] | (r_s1_p[k*GROUP+i] & v_c);
            end
        end

        w_sum = r_s1_p ^ w_carry;
        // Overflow: both addends share a sign and the result sign differs.
        w_ovf = (r_s1_a_msb == r_s1_bb_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);
    end

    // -------------------------------------------------------------------------
    // Stage 2 registers (outputs)
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            // Data only moves with a real item, so outputs hold while idle.
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_gc[NG];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;

`ifdef CLA_PIPE_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
            r_zero <= (w_sum == '0);
            r_neg  <= w_sum[WIDTH-1];
        end
    end

    assign bus.out_zero = r_zero;
    assign bus.out_neg  = r_neg;
`endif

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Scoreboard bench for cla_pipe_adder. Two instances share one stimulus
//   stream: WIDTH=32/GROUP=4 and WIDTH=16/GROUP=8 (low operand bits).
//   A driver process presents queued vectors and pushes expected results when
//   each transfer is accepted; independent monitors pop and compare whenever
//   a result is handed off. Set CLA_PIPE_FLAGS_EN to also check the flags.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    cla_pipe_adder_if #(.WIDTH(32)) bus32 ();
    cla_pipe_adder_if #(.WIDTH(16)) bus16 ();

    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus32)
    );

    cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    assign bus16.in_valid  = bus32.in_valid;
    assign bus16.in_a      = bus32.in_a[15:0];
    assign bus16.in_b      = bus32.in_b[15:0];
    assign bus16.in_cin    = bus32.in_cin;
    assign bus16.in_sub    = bus32.in_sub;
    assign bus16.out_ready = bus32.out_ready;

    vec_t stim_q[$];
    exp_t exp32_q[$];
    exp_t exp16_q[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    bit lat_mode  = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub, input int w,
                                  output logic [31:0] sum, output logic cout,
                                  output logic ovf);
        longint mask, half, ua, ub, sa, sb, full, r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        if (sub) begin
            full = ua - ub;
            cout = (ua >= ub);
            r    = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            cout = full[w];
            r    = sa + sb + longint'(cin);
        end
        sum = 32'(full & mask);
        ovf = (r > half - 1) || (r < -half);
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                input logic [31:0] sum, input logic cout, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.sum = sum; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Driver: present head of stim_q, push expectations on acceptance.
    // -------------------------------------------------------------------------
    initial begin
        bus32.in_valid = 1'b0;
        bus32.in_a     = '0;
        bus32.in_b     = '0;
        bus32.in_cin   = 1'b0;
        bus32.in_sub   = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (stim_q.size() > 0) begin
                bus32.in_valid = 1'b1;
                bus32.in_a     = stim_q[0].a;
                bus32.in_b     = stim_q[0].b;
                bus32.in_cin   = stim_q[0].cin;
                bus32.in_sub   = stim_q[0].sub;
            end else begin
                bus32.in_valid = 1'b0;
            end
            @(negedge clock);
            if (reset_n && bus32.in_valid && stim_q.size() > 0) begin
                if (bus32.in_ready && bus16.in_ready) begin
                    vec_t v;
                    exp_t e;
                    v         = stim_q.pop_front();
                    e.sum     = v.sum;
                    e.cout    = v.cout;
                    e.ovf     = v.ovf;
                    e.acc_cyc = cyc;
                    e.chk_lat = lat_mode;
                    exp32_q.push_back(e);
                    model(v.a, v.b, v.cin, v.sub, 16, e.sum, e.cout, e.ovf);
                    exp16_q.push_back(e);
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitors
    // -------------------------------------------------------------------------
    always @(negedge clock) begin
        if (reset_n && bus32.out_valid && bus32.out_ready) begin
            exp_t e;
            if (exp32_q.size() == 0) begin
                check("w32_unexpected_result", 64'(bus32.out_valid), 64'(0));
            end else begin
                e = exp32_q.pop_front();
                check("w32_sum",  64'(bus32.out_sum),  64'(e.sum));
                check("w32_cout", 64'(bus32.out_cout), 64'(e.cout));
                check("w32_ovf",  64'(bus32.out_ovf),  64'(e.ovf));
                if (e.chk_lat) check("w32_latency", 64'(cyc - e.acc_cyc), 64'(2));
`ifdef CLA_PIPE_FLAGS_EN
                check("w32_zero", 64'(bus32.out_zero), 64'(e.sum == 32'd0));
                check("w32_neg",  64'(bus32.out_neg),  64'(e.sum[31]));
`endif
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && bus16.out_valid && bus16.out_ready) begin
            exp_t e;
            if (exp16_q.size() == 0) begin
                check("w16_unexpected_result", 64'(bus16.out_valid), 64'(0));
            end else begin
                e = exp16_q.pop_front();
                check("w16_sum",  64'(bus16.out_sum),  64'(e.sum[15:0]));
                check("w16_cout", 64'(bus16.out_cout), 64'(e.cout));
                check("w16_ovf",  64'(bus16.out_ovf),  64'(e.ovf));
                if (e.chk_lat) check("w16_latency", 64'(cyc - e.acc_cyc), 64'(2));
`ifdef CLA_PIPE_FLAGS_EN
                check("w16_zero", 64'(bus16.out_zero), 64'(e.sum[15:0] == 16'd0));
                check("w16_neg",  64'(bus16.out_neg),  64'(e.sum[15]));
`endif
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((stim_q.size() != 0 || exp32_q.size() != 0 || exp16_q.size() != 0) && n < max_cyc) begin
            @(posedge clock);
            n++;
        end
        check("drain_pending_items", 64'(stim_q.size() + exp32_q.size() + exp16_q.size()), 64'(0));
        @(posedge clock);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        vec_t dir[10];
        vec_t v;

        dir[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir[1] = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        dir[2] = mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir[3] = mk(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        dir[4] = mk(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        dir[5] = mk(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir[6] = mk(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        dir[7] = mk(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        dir[8] = mk(32'h0FFF_FFF0, 32'h0000_0010, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
        dir[9] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        bus32.out_ready = 1'b1;
        reset_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #2;
        check("rst_out_valid",     64'(bus32.out_valid), 64'(0));
        check("rst_out_sum",       64'(bus32.out_sum),   64'(0));
        check("rst_out_cout",      64'(bus32.out_cout),  64'(0));
        check("rst_out_ovf",       64'(bus32.out_ovf),   64'(0));
        check("rst_in_ready",      64'(bus32.in_ready),  64'(1));
        check("rst_w16_out_valid", 64'(bus16.out_valid), 64'(0));
`ifdef CLA_PIPE_FLAGS_EN
        check("rst_out_zero", 64'(bus32.out_zero), 64'(0));
        check("rst_out_neg",  64'(bus32.out_neg),  64'(0));
`endif
        reset_n  = 1'b1;
        lat_mode = 1'b1;

        // Directed vectors, back to back, 2-cycle latency checked per item
        @(posedge clock);
        #2;
        for (int i = 0; i < 10; i++) stim_q.push_back(dir[i]);
        wait_drain(100);

        // Backpressure: consumer stalls while three items are offered
        lat_mode        = 1'b0;
        bus32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) stim_q.push_back(dir[i]);
        repeat (4) @(negedge clock);
        check("bp_in_ready",       64'(bus32.in_ready),  64'(0));
        check("bp_items_waiting",  64'(stim_q.size()),   64'(1));
        check("bp_out_valid",      64'(bus32.out_valid), 64'(1));
        check("bp_out_sum_held",   64'(bus32.out_sum),   64'(dir[0].sum));
        check("bp_w16_in_ready",   64'(bus16.in_ready),  64'(0));
        @(posedge clock);
        #2;
        bus32.out_ready = 1'b1;
        wait_drain(50);
        lat_mode = 1'b1;

        // Reset in the middle of a stream
        for (int i = 3; i < 7; i++) stim_q.push_back(dir[i]);
        repeat (3) @(posedge clock);
        #2;
        stim_q.delete();
        bus32.in_valid = 1'b0;
        reset_n        = 1'b0;
        #1;
        check("midrst_out_valid",     64'(bus32.out_valid), 64'(0));
        check("midrst_out_sum",       64'(bus32.out_sum),   64'(0));
        check("midrst_w16_out_valid", 64'(bus16.out_valid), 64'(0));
        exp32_q.delete();
        exp16_q.delete();
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("postrst_no_stale",     64'(bus32.out_valid), 64'(0));
        check("postrst_w16_no_stale", 64'(bus16.out_valid), 64'(0));

        // Random back-to-back stream, consumer always ready
        @(posedge clock);
        #2;
        stall_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            v.a   = $urandom;
            v.b   = $urandom;
            v.cin = 1'($urandom_range(0, 1));
            v.sub = 1'($urandom_range(0, 1));
            model(v.a, v.b, v.cin, v.sub, 32, v.sum, v.cout, v.ovf);
            stim_q.push_back(v);
        end
        wait_drain(1100);
        check("rand_no_input_stall", 64'(stall_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cla_pipe_adder
